// File: rtl/cga_wrf_rblock_rd16.sv
// Read side of the WRF 16-bit register block: parallel RA latch plus an
// LSB-first serial scan-out of the selected register.
module cga_wrf_rblock_rd16 #(
  parameter int unsigned NREG = 8,
  parameter int unsigned SELW = 4
) (
  input  logic                 ALUCLK,
  input  logic                 RESET_N,
  input  logic [NREG*16-1:0]   REGS_IN,
  input  logic [SELW-1:0]      RSEL,
  input  logic                 RD,
  input  logic                 SCAN,
  output logic [15:0]          RA_15_0,
  output logic                 RVALID,
  output logic                 SO,
  output logic                 SBUSY,
  output logic                 SDONE
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t          state;
  logic [DW-1:0]   shreg;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   sel;

  // Out-of-range selects read as zero.
  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (RSEL == SELW'(k)) sel = REGS_IN[DW*k +: DW];
    end
  end

  // SO is registered alongside the shifter so it always equals the new shreg[0].
  always_ff @(posedge ALUCLK) begin
    if (!RESET_N) begin
      RA_15_0 <= '0;
      RVALID  <= 1'b0;
      SO      <= 1'b0;
      SBUSY   <= 1'b0;
      SDONE   <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
      state   <= IDLE;
    end else begin
      if (RD) begin
        RA_15_0 <= sel;
        RVALID  <= 1'b1;
      end else begin
        RVALID  <= 1'b0;
      end

      case (state)
        IDLE: begin
          SO    <= 1'b0;
          SBUSY <= 1'b0;
          SDONE <= 1'b0;
          if (SCAN) begin
            state <= LOAD;
            shreg <= sel;
            SO    <= sel[0];
            SBUSY <= 1'b1;
            cnt   <= '0;
          end
        end
        LOAD: begin
          state <= SHIFT;
          shreg <= {1'b0, shreg[DW-1:1]};
          SO    <= shreg[1];
          cnt   <= cnt + CW'(1);
        end
        SHIFT: begin
          shreg <= {1'b0, shreg[DW-1:1]};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(15)) begin
            state <= DONE;
            SO    <= 1'b0;
            SBUSY <= 1'b0;
            SDONE <= 1'b1;
          end else begin
            SO    <= shreg[1];
          end
        end
        DONE: begin
          state <= IDLE;
          SO    <= 1'b0;
          SBUSY <= 1'b0;
          SDONE <= 1'b0;
        end
        default: begin
          state <= IDLE;
          SO    <= 1'b0;
          SBUSY <= 1'b0;
          SDONE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cga_wrf_rblock_rd16.sv
// Bench for cga_wrf_rblock_rd16: scan position model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cga_wrf_rblock_rd16;

  localparam int NREG = 8;
  localparam int SELW = 4;

  logic               ALUCLK = 1'b0;
  logic               RESET_N;
  logic [NREG*16-1:0] REGS_IN;
  logic [SELW-1:0]    RSEL;
  logic               RD;
  logic               SCAN;
  logic [15:0]        RA_15_0;
  logic               RVALID;
  logic               SO;
  logic               SBUSY;
  logic               SDONE;

  cga_wrf_rblock_rd16 #(.NREG(NREG), .SELW(SELW)) dut (
    .ALUCLK(ALUCLK), .RESET_N(RESET_N), .REGS_IN(REGS_IN), .RSEL(RSEL),
    .RD(RD), .SCAN(SCAN), .RA_15_0(RA_15_0), .RVALID(RVALID), .SO(SO),
    .SBUSY(SBUSY), .SDONE(SDONE)
  );

  always #5 ALUCLK = ~ALUCLK;

  int vectors = 0;
  int miscompares = 0;

  // Model: pos = -1 idle, 0..15 index of bit on SO, 16 = done cycle.
  int          pos = -1;
  logic [15:0] cap = '0;
  logic [15:0] m_ra = '0;
  logic        m_rv = 1'b0;

  function automatic logic [15:0] sel_val(input logic [NREG*16-1:0] regs,
                                          input logic [SELW-1:0] rs);
    int r;
    r = int'(rs);
    if (r < NREG) return 16'(regs >> (16 * r));
    return 16'h0000;
  endfunction

  task automatic model_edge();
    logic [15:0] s;
    s = sel_val(REGS_IN, RSEL);
    if (!RESET_N) begin
      pos = -1; cap = '0; m_ra = '0; m_rv = 1'b0;
    end else begin
      if (RD) begin m_ra = s; m_rv = 1'b1; end
      else m_rv = 1'b0;
      if (pos == -1) begin
        if (SCAN) begin cap = s; pos = 0; end
      end else if (pos == 16) begin
        pos = -1;
      end else begin
        pos = pos + 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic compare_model();
    logic busy;
    logic eso;
    busy = (pos >= 0) && (pos <= 15);
    eso  = busy ? cap[pos] : 1'b0;
    chk("ra", RA_15_0, m_ra);
    chk("rvalid", 16'(RVALID), 16'(m_rv));
    chk("so", 16'(SO), 16'(eso));
    chk("sbusy", 16'(SBUSY), 16'(busy));
    chk("sdone", 16'(SDONE), 16'(pos == 16));
  endtask

  task automatic step();
    @(posedge ALUCLK);
    model_edge();
    #1;
    vectors++;
    compare_model();
  endtask

  task automatic set_reg(input int k, input logic [15:0] v);
    REGS_IN[16*k +: 16] = v;
  endtask

  initial begin
    RESET_N = 1'b0; RD = 1'b1; SCAN = 1'b1; RSEL = '0;
    REGS_IN = '0;
    for (int k = 0; k < NREG; k++) set_reg(k, 16'(16'h1111 * (k + 1)));

    // Reset with requests asserted
    repeat (2) begin
      step();
      chk("rst_ra", RA_15_0, 16'h0000);
      chk("rst_rvalid", 16'(RVALID), 16'h0);
      chk("rst_so", 16'(SO), 16'h0);
      chk("rst_sbusy", 16'(SBUSY), 16'h0);
      chk("rst_sdone", 16'(SDONE), 16'h0);
    end
    RESET_N = 1'b1; RD = 1'b0; SCAN = 1'b0;
    step();
    chk("idle_sbusy", 16'(SBUSY), 16'h0);

    // Parallel read
    set_reg(3, 16'hA5C3); RSEL = 4'd3; RD = 1'b1;
    step();
    chk("rd_ra", RA_15_0, 16'hA5C3);
    chk("rd_rvalid", 16'(RVALID), 16'h1);
    RD = 1'b0;
    step();
    chk("rd_hold_ra", RA_15_0, 16'hA5C3);
    chk("rd_hold_rvalid", 16'(RVALID), 16'h0);

    // Out-of-range select
    RSEL = 4'd9; RD = 1'b1;
    step();
    chk("oor_ra", RA_15_0, 16'h0000);
    chk("oor_rvalid", 16'(RVALID), 16'h1);
    RD = 1'b0;
    step();

    // Scan of 8001 with isolation traffic mid-scan
    set_reg(1, 16'h8001); set_reg(2, 16'h1234); RSEL = 4'd1; SCAN = 1'b1;
    step();
    chk("scan_so0", 16'(SO), 16'h1);
    chk("scan_busy0", 16'(SBUSY), 16'h1);
    SCAN = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      if (n == 4) begin
        set_reg(1, 16'hFFFF); SCAN = 1'b1; RSEL = 4'd2; RD = 1'b1;
      end else if (n == 5) begin
        SCAN = 1'b0; RD = 1'b0;
      end
      step();
      chk("scan_so", 16'(SO), 16'((n == 15) ? 1 : 0));
      chk("scan_busy", 16'(SBUSY), 16'h1);
      if (n == 4) begin
        chk("iso_ra", RA_15_0, 16'h1234);
        chk("iso_rvalid", 16'(RVALID), 16'h1);
      end
    end
    step();
    chk("done_sdone", 16'(SDONE), 16'h1);
    chk("done_sbusy", 16'(SBUSY), 16'h0);
    chk("done_so", 16'(SO), 16'h0);
    step();
    chk("post_sdone", 16'(SDONE), 16'h0);
    chk("post_sbusy", 16'(SBUSY), 16'h0);

    // Reset mid-scan at counter 7, then restart from bit 0
    set_reg(1, 16'h00AA); RSEL = 4'd1; SCAN = 1'b1;
    step();
    SCAN = 1'b0;
    repeat (7) step();
    chk("mid_busy", 16'(SBUSY), 16'h1);
    chk("mid_so7", 16'(SO), 16'h1);
    RESET_N = 1'b0;
    step();
    chk("abort_sbusy", 16'(SBUSY), 16'h0);
    chk("abort_so", 16'(SO), 16'h0);
    chk("abort_sdone", 16'(SDONE), 16'h0);
    RESET_N = 1'b1;
    repeat (3) begin
      step();
      chk("abort_nodone", 16'(SDONE), 16'h0);
    end
    set_reg(1, 16'h0005); SCAN = 1'b1;
    step();
    chk("restart_so0", 16'(SO), 16'h1);
    SCAN = 1'b0;
    step();
    chk("restart_so1", 16'(SO), 16'h0);
    step();
    chk("restart_so2", 16'(SO), 16'h1);
    repeat (16) step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < NREG; k++) set_reg(k, 16'($urandom));
      end
      RSEL    = SELW'($urandom_range(0, 15));
      RD      = 1'($urandom_range(0, 1));
      SCAN    = ($urandom_range(0, 9) < 3);
      RESET_N = ($urandom_range(0, 99) >= 2);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
